// File: rtl/polar_u_assembler.sv
// rtl/polar_u_assembler.sv - builds the polar u vector from frozen mask and serial info bits
//
// Ports:
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   start         frame request, only looked at in IDLE
//   frozen_mask   bit i=1 -> position i frozen; captured when start is accepted
//   in_valid/in_ready/in_bit/in_last   serial information-bit stream
//   busy          high while the frame is being filled
//   u_out/u_valid assembled vector and its one-cycle valid pulse (encoder valid_in)
//   frame_err     early or late in_last seen on the frame just emitted
module polar_u_assembler #(
  parameter int N     = 256,
  parameter int LOG2N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] frozen_mask,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  input  logic         in_last,
  output logic         busy,
  output logic [N-1:0] u_out,
  output logic         u_valid,
  output logic         frame_err
);

  localparam logic [N-1:0]     ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N-1);
  localparam logic [LOG2N-1:0] IDX_ONE  = LOG2N'(1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state;
  logic [LOG2N-1:0] idx;
  logic [N-1:0]     mask_q;
  logic [N-1:0]     u_q;
  logic             early;
  logic             late;

  logic [N-1:0]     idx_onehot;
  logic [N-1:0]     info_above;
  logic [N-1:0]     u_next;
  logic             info_pos;
  logic             accept;
  logic             advance;
  logic             more_info;
  logic             early_set;
  logic             late_set;
  logic             last_pos;

  always_comb begin
    idx_onehot = ONE_N << idx;
    // Info positions strictly above idx. At idx=N-1 the shifted one-hot is
    // zero, so the mask collapses to zero as well.
    info_above = ~mask_q & ~((idx_onehot << 1) - ONE_N);
    more_info  = |info_above;
    info_pos   = ~mask_q[idx];
    in_ready   = (state == FILL) && info_pos && !early;
    accept     = in_ready && in_valid;
    // Frozen and zero-filled positions never wait for input.
    advance    = (state == FILL) && (!info_pos || early || in_valid);
    early_set  = accept && in_last && more_info;
    late_set   = accept && !in_last && !more_info;
    last_pos   = (idx == IDX_LAST);
    u_next     = (accept && in_bit) ? (u_q | idx_onehot) : u_q;
    busy       = (state == FILL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      mask_q    <= '0;
      u_q       <= '0;
      early     <= 1'b0;
      late      <= 1'b0;
      u_out     <= '0;
      u_valid   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      u_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask_q <= frozen_mask;
            u_q    <= '0;
            idx    <= '0;
            early  <= 1'b0;
            late   <= 1'b0;
            state  <= FILL;
          end
        end
        FILL: begin
          if (advance) begin
            u_q <= u_next;
            if (early_set) early <= 1'b1;
            if (late_set)  late  <= 1'b1;
            if (last_pos) begin
              // Fold in flags raised by this very position (late on N-1).
              u_out     <= u_next;
              u_valid   <= 1'b1;
              frame_err <= early | early_set | late | late_set;
              state     <= IDLE;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polar_u_assembler.sv
// tb/tb_polar_u_assembler.sv - scoreboard bench for polar_u_assembler
module tb_polar_u_assembler;

  localparam int N     = 256;
  localparam int LOG2N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] frozen_mask;
  logic         in_valid;
  logic         in_ready;
  logic         in_bit;
  logic         in_last;
  logic         busy;
  logic [N-1:0] u_out;
  logic         u_valid;
  logic         frame_err;

  polar_u_assembler #(.N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frozen_mask(frozen_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .busy(busy), .u_out(u_out), .u_valid(u_valid), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic last;
    int   gap;   // in_ready cycles the producer holds off before offering this bit
  } item_t;

  typedef struct {
    logic [N-1:0] u;
    logic         err;
    int           lat;
    int           hs;
    int           rdy;
    bit           chk_int;
  } exp_t;

  item_t drv_q[$];
  item_t mdl_q[$];
  exp_t  sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int n_info(input logic [N-1:0] m);
    int c = 0;
    for (int p = 0; p < N; p++) if (!m[p]) c++;
    return c;
  endfunction

  // Reference: walk the info positions in order; each one takes the next
  // stream bit unless in_last already closed the frame early.
  task automatic model_frame(input logic [N-1:0] mask, input int mode, input int k,
                             input bit pat, input bit rgap, input int gap10_at,
                             input bit chk_int);
    int           total;
    int           seen   = 0;
    int           stalls = 0;
    int           cons   = 0;
    logic         early  = 1'b0;
    logic         late   = 1'b0;
    logic [N-1:0] u      = '0;
    item_t        it;
    exp_t         e;
    total = n_info(mask);
    for (int p = 0; p < N; p++) begin
      if (!mask[p]) begin
        if (!early) begin
          if (mdl_q.size() > 0) begin
            it = mdl_q.pop_front();
          end else begin
            it.b    = pat ? p[0] : 1'($urandom_range(0, 1));
            it.last = (mode == 0 && seen == total - 1) || (mode == 1 && seen == k);
            it.gap  = (rgap && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (seen == gap10_at) it.gap = 10;
            drv_q.push_back(it);
          end
          u[p] = it.b;
          cons++;
          stalls += it.gap;
          if (it.last && seen < total - 1) early = 1'b1;
          if (!it.last && seen == total - 1) late = 1'b1;
        end
        seen++;
      end
    end
    if (mode == 2) begin
      // Producer keeps going: this bit belongs to the next frame.
      it.b    = 1'($urandom_range(0, 1));
      it.last = 1'b0;
      it.gap  = 0;
      drv_q.push_back(it);
      mdl_q.push_back(it);
    end
    e.u       = u;
    e.err     = early | late;
    e.lat     = N + stalls;
    e.hs      = cons;
    e.rdy     = cons + stalls;
    e.chk_int = chk_int;
    sb.push_back(e);
  endtask

  task automatic do_frame(input logic [N-1:0] mask, input int mode, input int k,
                          input bit pat, input bit rgap, input int gap10_at,
                          input bit hold, input bit chk_int);
    int t = 0;
    @(negedge clk);
    while (busy) begin
      @(negedge clk);
      t++;
      if (t > 5000) begin
        n_cmp++;
        n_err++;
        $display("FAIL launch_timeout: busy stuck high");
        return;
      end
    end
    model_frame(mask, mode, k, pat, rgap, gap10_at, chk_int);
    frozen_mask = mask;
    start       = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    // Must be ignored: the captured mask is in use now.
    frozen_mask = {8{$urandom()}};
  endtask

  // Producer
  initial begin
    item_t cur;
    bit    have = 0;
    int    gap  = 0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!have && drv_q.size() > 0) begin
        cur  = drv_q.pop_front();
        gap  = cur.gap;
        have = 1;
      end
      if (have) begin
        in_bit  = cur.b;
        in_last = cur.last;
        if (gap > 0) begin
          in_valid = 1'b0;
          if (in_ready) gap--;
        end else begin
          in_valid = 1'b1;
          if (in_ready) have = 0;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  // Monitor
  int cyc     = 0;
  int last_uv = 0;
  int cb      = 0;
  int cr      = 0;
  int ch      = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        cb = 0; cr = 0; ch = 0;
      end else begin
        if (busy) cb++;
        if (in_ready) cr++;
        if (in_ready && in_valid) ch++;
        if (u_valid) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_u_valid: got u_valid=1 expected no frame");
          end else begin
            e = sb.pop_front();
            chk("u_out", u_out, e.u);
            chk("frame_err", N'(frame_err), N'(e.err));
            chk("latency", N'(cb), N'(e.lat));
            chk("handshakes", N'(ch), N'(e.hs));
            chk("ready_cycles", N'(cr), N'(e.rdy));
            if (e.chk_int) chk("b2b_interval", N'(cyc - last_uv), N'(N + 1));
          end
          last_uv = cyc;
          cb = 0; cr = 0; ch = 0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] m;
    int           mode;
    int           k;
    int           pct;
    int           ni;
    int           t;

    rst_n       = 1'b0;
    start       = 1'b0;
    frozen_mask = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_u_out", u_out, '0);
    chk("rst_u_valid", N'(u_valid), '0);
    chk("rst_busy", N'(busy), '0);
    chk("rst_in_ready", N'(in_ready), '0);
    chk("rst_frame_err", N'(frame_err), '0);
    rst_n = 1'b1;

    // Lower half frozen, alternating bits, in-order last
    m = {{(N/2){1'b0}}, {(N/2){1'b1}}};
    do_frame(m, 0, 0, 1, 0, -1, 0, 0);
    // Same, 10-cycle stall mid-frame
    do_frame(m, 0, 0, 1, 0, 64, 0, 0);
    // Info {3,200}, last on the first one
    m = '1; m[3] = 1'b0; m[200] = 1'b0;
    do_frame(m, 1, 0, 1, 0, -1, 0, 0);
    // Four info positions, no in_last; leftover bit opens the next frame
    m = '1; m[10] = 1'b0; m[77] = 1'b0; m[150] = 1'b0; m[255] = 1'b0;
    do_frame(m, 2, 0, 0, 0, -1, 0, 0);
    do_frame(m, 0, 0, 0, 0, -1, 0, 0);
    // All frozen
    do_frame('1, 0, 0, 0, 0, -1, 0, 0);

    for (int f = 0; f < 16; f++) begin
      case ($urandom_range(0, 3))
        0:       pct = 0;
        1:       pct = 50;
        2:       pct = 90;
        default: pct = 98;
      endcase
      for (int p = 0; p < N; p++) m[p] = ($urandom_range(0, 99) < pct);
      ni   = n_info(m);
      mode = $urandom_range(0, 2);
      if (ni == 0) mode = 0;
      if (mode == 1 && ni < 2) mode = 0;
      k = (mode == 1) ? int'($urandom_range(0, ni - 2)) : 0;
      do_frame(m, mode, k, 0, 1, -1, 0, 0);
    end

    // start held high: frames every N+1 cycles
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < N; p++) m[p] = ($urandom_range(0, 1) == 1);
      m[0] = 1'b0;
      do_frame(m, 0, 0, 0, 0, -1, (f < 2), (f > 0));
    end

    // Reset in the middle of an all-frozen frame
    do_frame('1, 0, 0, 0, 0, -1, 0, 0);
    void'(sb.pop_back());
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("midrst_u_out", u_out, '0);
    chk("midrst_u_valid", N'(u_valid), '0);
    chk("midrst_busy", N'(busy), '0);
    chk("midrst_frame_err", N'(frame_err), '0);
    repeat (300) @(negedge clk);

    t = 0;
    while (sb.size() > 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("frames_left", N'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
